serial_transmitter: RTL and testbench

SERIAL_TRANSMITTER -- requirements
Module: serial_transmitter

---
 rtl/serial_tx_pkg.sv | 17 +
 rtl/bit_counter.sv | 41 ++++
 rtl/serial_transmitter.sv | 145 ++++++++++++++
 tb/tb_serial_transmitter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types and default widths for the serial transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_tx_pkg;

    localparam int LEN_W_DEF  = 4;
    localparam int PORT_W_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PORT,
        ST_LEN,
        ST_DATA,
        ST_DONE
    } state_e;

endpackage

// File: rtl/bit_counter.sv
// Loadable down-counter with zero flag; holds the remaining data-bit count.
// Latency: load/decrement visible one clock after the request.
// Backpressure: none; decrement is ignored when the count is already zero.
module bit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load has priority; decrement saturates at zero so the count never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/serial_transmitter.sv
// Frame parser: after a start pulse reads port id and length from SIn, then routes data bits to one port.
// Latency: data bit appears on port_out one clock after it is sampled; done follows the last data bit.
// Backpressure: none; start pulses arriving while a frame is in progress are dropped.
module serial_transmitter
    import serial_tx_pkg::*;
#(
    parameter int LEN_W  = LEN_W_DEF,
    parameter int PORT_W = PORT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SIn,
    input  logic                 detected,
    output logic [2**PORT_W-1:0] port_out,
    output logic [2**PORT_W-1:0] port_valid,
    output logic                 busy,
    output logic [LEN_W-1:0]     cnt_rem,
    output logic                 done
);

    localparam int NPORT = 2**PORT_W;
    localparam int MAX_W = (LEN_W > PORT_W) ? LEN_W : PORT_W;
    localparam int IDX_W = $clog2(MAX_W) + 1;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [PORT_W-1:0]   port_sel_q, port_sel_d;
    logic [NPORT-1:0]    port_out_q, port_out_d;
    logic [NPORT-1:0]    port_valid_q, port_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                cnt_load;
    logic [LEN_W-1:0]    cnt_load_val;
    logic                cnt_dec;
    logic [LEN_W-1:0]    cnt_val;
    logic                cnt_zero;
    logic [LEN_W-1:0]    len_shift;

    // The length field is shifted directly into the down-counter, MSB first.
    assign len_shift = (cnt_val << 1) | LEN_W'(SIn);

    bit_counter #(
        .W (LEN_W)
    ) u_bit_counter (
        .clk      (clk),
        .rst_n    (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .cnt      (cnt_val),
        .zero     (cnt_zero)
    );

    // Next-state, header shifting and per-port demux of the data bit.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        port_sel_d   = port_sel_q;
        port_out_d   = '0;
        port_valid_d = '0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (detected) begin
                    // Clear header state so an aborted frame leaves nothing behind.
                    state_d    = ST_PORT;
                    idx_d      = '0;
                    port_sel_d = '0;
                    cnt_load   = 1'b1;
                end
            end
            ST_PORT: begin
                port_sel_d = (port_sel_q << 1) | PORT_W'(SIn);
                if (idx_q == IDX_W'(PORT_W - 1)) begin
                    idx_d   = '0;
                    state_d = ST_LEN;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_LEN: begin
                cnt_load     = 1'b1;
                cnt_load_val = len_shift;
                if (idx_q == IDX_W'(LEN_W - 1)) begin
                    idx_d   = '0;
                    state_d = (len_shift != '0) ? ST_DATA : ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DATA: begin
                // One data bit per cycle while the count is nonzero; the
                // cycle that sees zero only hands over to DONE.
                if (!cnt_zero) begin
                    cnt_dec                  = 1'b1;
                    port_out_d[port_sel_q]   = SIn;
                    port_valid_d[port_sel_q] = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            port_sel_q   <= '0;
            port_out_q   <= '0;
            port_valid_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            port_sel_q   <= port_sel_d;
            port_out_q   <= port_out_d;
            port_valid_q <= port_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign port_out   = port_out_q;
    assign port_valid = port_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cnt_rem    = cnt_val;

endmodule

// File: tb/tb_serial_transmitter.sv
module tb_serial_transmitter;

    localparam int LEN_W  = 4;
    localparam int PORT_W = 2;
    localparam int NPORT  = 4;

    logic             clk;
    logic             rst;
    logic             SIn;
    logic             detected;
    logic [NPORT-1:0] port_out;
    logic [NPORT-1:0] port_valid;
    logic             busy;
    logic [LEN_W-1:0] cnt_rem;
    logic             done;

    serial_transmitter #(
        .LEN_W  (LEN_W),
        .PORT_W (PORT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .SIn        (SIn),
        .detected   (detected),
        .port_out   (port_out),
        .port_valid (port_valid),
        .busy       (busy),
        .cnt_rem    (cnt_rem),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cyc;
        bit is_done;
        int port;
        bit dat;
    } exp_t;

    exp_t sb[$];

    // Current frame window used for busy / cnt_rem expectations.
    int w_from = 0;
    int w_to   = 0;
    int w_len  = 0;
    int w_el   = 0;
    int w_hdr  = 0;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", nm, cyc, act, expv);
        end
    endtask

    function automatic int exp_busy(input int c);
        return (c >= w_from && c < w_to) ? 1 : 0;
    endfunction

    function automatic int exp_cnt(input int c);
        int j;
        if (c < w_from || c >= w_to) return 0;
        if (w_len > 0 && c >= w_el && c <= w_el + w_len) return w_len - (c - w_el);
        j = c - w_hdr;
        if (j >= 0 && j <= LEN_W) return w_len >> (LEN_W - j);
        return 0;
    endfunction

    // Monitor: invariants every cycle, scoreboard pop on every output event.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   pi;
        chk("onehot_valid", ($countones(port_valid) <= 1) ? 1 : 0, 1);
        chk("unselected_port_out", int'(port_out & ~port_valid), 0);
        chk("busy", int'(busy), exp_busy(cyc));
        chk("cnt_rem", int'(cnt_rem), exp_cnt(cyc));
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event: expected at cycle %0d (done=%0d), none by cycle %0d",
                     e.cyc, e.is_done, cyc);
        end
        if (port_valid != '0) begin
            pi = 0;
            for (int i = 0; i < NPORT; i++) if (port_valid[i]) pi = i;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid @cycle %0d: got port %0d, expected nothing", cyc, pi);
            end else begin
                e = sb.pop_front();
                chk("valid_cycle", cyc, e.cyc);
                chk("valid_kind", 0, int'(e.is_done));
                chk("valid_port", pi, e.port);
                chk("valid_data", int'(port_out[pi]), int'(e.dat));
            end
        end
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done @cycle %0d: got done=1, expected nothing", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("done_kind", 1, int'(e.is_done));
            end
        end
    end

    task automatic step(input bit d, input bit s);
        detected = d;
        SIn      = s;
        @(posedge clk);
        #1;
    endtask

    function automatic bit nz(input bit noise);
        return noise ? ($urandom_range(0, 3) == 0) : 1'b0;
    endfunction

    // One frame: start pulse, port, length, data. abort_k>0 resets the DUT
    // right after the abort_k-th data bit has been sampled.
    task automatic run_frame(input int port, input int len, input bit [15:0] dv,
                             input bit noise, input bit last_det, input int abort_k);
        bit [PORT_W-1:0] pv;
        bit [LEN_W-1:0]  lv;
        int              p1, el, idle_e;
        exp_t            e;
        pv     = PORT_W'(port);
        lv     = LEN_W'(len);
        p1     = cyc + 1;
        el     = p1 + PORT_W + LEN_W;
        idle_e = (len > 0) ? el + len + 2 : el + 1;
        w_from = p1;
        w_to   = idle_e;
        w_len  = len;
        w_el   = el;
        w_hdr  = p1 + PORT_W;
        for (int k = 1; k <= len; k++) begin
            if (abort_k < 0 || k < abort_k) begin
                e.cyc = el + k; e.is_done = 1'b0; e.port = port; e.dat = dv[k-1];
                sb.push_back(e);
            end
        end
        if (abort_k < 0) begin
            e.cyc = (len > 0) ? el + len + 1 : el; e.is_done = 1'b1; e.port = 0; e.dat = 1'b0;
            sb.push_back(e);
        end
        step(1'b1, 1'($urandom_range(0, 1)));
        for (int i = PORT_W - 1; i >= 0; i--) step(nz(noise), pv[i]);
        for (int i = LEN_W - 1; i >= 0; i--) step(nz(noise), lv[i]);
        for (int k = 0; k < len; k++) begin
            step(nz(noise), dv[k]);
            if (abort_k == k + 1) begin
                chk("cnt_before_reset", int'(cnt_rem), len - abort_k);
                detected = 1'b0;
                #1;
                rst    = 1'b0;
                w_from = 0;
                w_to   = 0;
                #1;
                chk("rst_port_out", int'(port_out), 0);
                chk("rst_port_valid", int'(port_valid), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_cnt_rem", int'(cnt_rem), 0);
                chk("rst_done", int'(done), 0);
                @(negedge clk);
                @(negedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
        end
        if (len > 0) step(nz(noise), 1'($urandom_range(0, 1)));
        step(last_det ? 1'b1 : nz(noise), 1'($urandom_range(0, 1)));
        detected = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b0;
        SIn      = 1'b0;
        detected = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_cnt_rem", int'(cnt_rem), 0);
        chk("reset_port_valid", int'(port_valid), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Port 2, length 3, data 1,0,1.
        run_frame(2, 3, 16'b101, 1'b0, 1'b0, -1);
        repeat (2) step(1'b0, 1'b0);
        // Zero length: straight to DONE.
        run_frame(1, 0, 16'h0, 1'b0, 1'b0, -1);
        repeat (2) step(1'b0, 1'b0);
        // Maximum length with stray start pulses throughout.
        run_frame(3, 15, 16'($urandom), 1'b1, 1'b0, -1);
        repeat (2) step(1'b0, 1'b0);
        // Reset mid-DATA with 5 bits left, then a clean frame.
        run_frame(1, 9, 16'($urandom), 1'b0, 1'b0, 4);
        run_frame(2, 4, 16'($urandom), 1'b0, 1'b0, -1);
        // Start pulse during DONE is ignored; next one in IDLE starts a frame.
        run_frame(1, 5, 16'($urandom), 1'b0, 1'b1, -1);
        run_frame(0, 2, 16'($urandom), 1'b0, 1'b0, -1);
        repeat (2) step(1'b0, 1'b0);

        for (int n = 0; n < 25; n++) begin
            run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                      16'($urandom), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), -1);
            if ($urandom_range(0, 1) == 1) step(1'b0, 1'($urandom_range(0, 1)));
        end

        repeat (5) step(1'b0, 1'b0);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
